// File: rtl/writeback_arbiter_if.sv
// Writeback bundle: ALU/load results in, decode reservation and hazard queries, RF write port out.
// Latency: none, signal bundle only.
// Backpressure: alu_ready/ld_ready flow back to the producers; rsv_full tells decode to stall.
interface writeback_arbiter_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        rsv_full;
  logic [4:0]  qry_addr_0;
  logic [4:0]  qry_addr_1;
  logic        pend_0;
  logic        pend_1;
  logic        rf_write_en;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  ld_valid, ld_addr, ld_data,
    input  rsv_en, rsv_addr, qry_addr_0, qry_addr_1,
    output alu_ready, ld_ready, rsv_full, pend_0, pend_1,
    output rf_write_en, rf_write_addr, rf_write_data
  );

  modport master (
    output alu_valid, alu_addr, alu_data,
    output ld_valid, ld_addr, ld_data,
    output rsv_en, rsv_addr, qry_addr_0, qry_addr_1,
    input  alu_ready, ld_ready, rsv_full, pend_0, pend_1,
    input  rf_write_en, rf_write_addr, rf_write_data
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges ALU results and FIFO-buffered load results onto the single RF write port; tracks outstanding writes.
// Latency: ALU accept -> RF write next cycle; load accept -> RF write two or more cycles later.
// Backpressure: ALU stalls while the load queue drains; loads stall only when the queue is full and not draining.
module writeback_arbiter #(
  parameter int LQ_DEPTH = 4,
  parameter int CNT_W    = 2
) (
  input logic               clk,
  input logic               rst,
  writeback_arbiter_if.slave wb
);

  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // load-result queue
  logic [4:0]    lq_addr [LQ_DEPTH];
  logic [31:0]   lq_data [LQ_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;

  // per-register outstanding-write counters
  logic [CNT_W-1:0] cnt [32];

  // registered RF write port
  logic        wr_en_q;
  logic [4:0]  wr_addr_q;
  logic [31:0] wr_data_q;

  logic        drain_ld;
  logic        alu_fire;
  logic        ld_push;
  logic        grant_vld;
  logic [4:0]  grant_addr;
  logic [31:0] grant_data;
  logic        rsv_full;
  logic [31:0] inc_vec;
  logic [31:0] dec_vec;

  // The load queue drains when the ALU is idle or the queue is nearly full, so
  // loads cannot be starved by a continuous ALU stream.
  assign drain_ld = (fifo_count != '0) &&
                    (!wb.alu_valid || fifo_count >= CW'(LQ_DEPTH - 1));
  assign alu_fire = wb.alu_valid && !drain_ld;
  // A full queue can still accept when its head pops in the same cycle.
  assign ld_push  = wb.ld_valid && wb.ld_ready;

  assign wb.alu_ready = !drain_ld;
  assign wb.ld_ready  = (fifo_count < CW'(LQ_DEPTH)) || drain_ld;

  assign grant_vld  = drain_ld || alu_fire;
  assign grant_addr = drain_ld ? lq_addr[rd_ptr] : wb.alu_addr;
  assign grant_data = drain_ld ? lq_data[rd_ptr] : wb.alu_data;

  assign rsv_full    = wb.rsv_en && (wb.rsv_addr != 5'd0) && (cnt[wb.rsv_addr] == CNT_MAX);
  assign wb.rsv_full = rsv_full;
  assign wb.pend_0   = (wb.qry_addr_0 != 5'd0) && (cnt[wb.qry_addr_0] != '0);
  assign wb.pend_1   = (wb.qry_addr_1 != 5'd0) && (cnt[wb.qry_addr_1] != '0);

  assign wb.rf_write_en   = wr_en_q;
  assign wb.rf_write_addr = wr_addr_q;
  assign wb.rf_write_data = wr_data_q;

  // Queue storage is data-only; validity comes from the pointers, so it needs no reset.
  always_ff @(posedge clk) begin
    if (ld_push) begin
      lq_addr[wr_ptr] <= wb.ld_addr;
      lq_data[wr_ptr] <= wb.ld_data;
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (ld_push)  wr_ptr <= wr_ptr + 1'b1;
      if (drain_ld) rd_ptr <= rd_ptr + 1'b1;
      if (ld_push && !drain_ld)      fifo_count <= fifo_count + 1'b1;
      else if (!ld_push && drain_ld) fifo_count <= fifo_count - 1'b1;
    end
  end

  // Register the granted result; writes to r0 use the slot but never reach the RF.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= grant_vld && (grant_addr != 5'd0);
      if (grant_vld && (grant_addr != 5'd0)) begin
        wr_addr_q <= grant_addr;
        wr_data_q <= grant_data;
      end
    end
  end

  // One-hot increment/decrement requests for the scoreboard.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (wb.rsv_en && !rsv_full && (wb.rsv_addr != 5'd0)) inc_vec[wb.rsv_addr] = 1'b1;
    if (wr_en_q && (cnt[wr_addr_q] != '0))               dec_vec[wr_addr_q]   = 1'b1;
  end

  // Outstanding-write counters; a reservation and a retiring write on the same register cancel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 32; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        if (inc_vec[r] && !dec_vec[r])      cnt[r] <= cnt[r] + 1'b1;
        else if (dec_vec[r] && !inc_vec[r]) cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

endmodule
